// File: rtl/sccpu_run_ctrl_pkg.sv
// Shared debug-controller definitions: run-state encodings, halt reason
// codes and the default halt-instruction encoding.
package sccpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } run_state_e;

    typedef enum logic [2:0] {
        RSN_NONE   = 3'd0,
        RSN_USER   = 3'd1,
        RSN_BP     = 3'd2,
        RSN_HINST  = 3'd3,
        RSN_BUDGET = 3'd4
    } halt_rsn_e;

    localparam logic [31:0] HALT_INST_DEF = 32'h0000_000C;
    localparam int          CNT_W_DEF     = 32;

    // Word-address compare: byte offset bits are ignored.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/sccpu_run_ctrl_if.sv
// Debug-host / IF-stage bundle seen by the run controller. The host side
// (master) drives requests and the current fetch; the controller (slave)
// returns the CPU enable and status.
interface sccpu_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [CNT_W-1:0] max_cycles;
    logic             cnt_clr;
    logic [31:0]      pc;
    logic [31:0]      inst;

    logic             cpu_en;
    logic [1:0]       state;
    logic [2:0]       halt_reason;
    logic             step_done;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output run_req, step_req, halt_req, bp_en, bp_addr, max_cycles,
               cnt_clr, pc, inst,
        input  cpu_en, state, halt_reason, step_done, retired_cnt
    );

    modport slave (
        input  run_req, step_req, halt_req, bp_en, bp_addr, max_cycles,
               cnt_clr, pc, inst,
        output cpu_en, state, halt_reason, step_done, retired_cnt
    );
endinterface

// File: rtl/sccpu_run_ctrl_stop_detect.sv
// Combinational stop detection on the instruction currently in IF:
// halt-instruction match and (unsuppressed) PC breakpoint match.
module sccpu_stop_detect
    import sccpu_dbg_pkg::*;
#(
    parameter logic [31:0] HALT_INST = HALT_INST_DEF
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        bp_en_i,
    input  logic [31:0] bp_addr_i,
    input  logic        bp_skip_i,
    output logic        hit_halt_o,
    output logic        hit_bp_o
);

    // The halt instruction is caught before it executes.
    assign hit_halt_o = (inst_i == HALT_INST);

    // bp_skip masks the breakpoint for the first instruction after a resume,
    // so restarting from the breakpoint PC makes forward progress.
    assign hit_bp_o = bp_en_i && same_word(pc_i, bp_addr_i) && !bp_skip_i;

endmodule

// File: rtl/sccpu_run_ctrl.sv
// Run/step/halt controller for the single-cycle CPU. Produces the global
// clock enable (one enabled cycle = one retired instruction), tracks why
// the core stopped, and counts retired instructions.
module sccpu_run_ctrl
    import sccpu_dbg_pkg::*;
#(
    parameter logic [31:0] HALT_INST = HALT_INST_DEF,
    parameter int          CNT_W     = CNT_W_DEF
) (
    input  logic               Clock,
    input  logic               Resetn,
    sccpu_run_ctrl_if.slave    bus
);

    run_state_e       state_q, state_d;
    halt_rsn_e        rsn_q, rsn_d;
    logic             step_done_q, step_done_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             bp_skip_q, bp_skip_d;

    logic             cpu_en;
    logic             hit_halt;
    logic             hit_bp;
    logic [CNT_W-1:0] run_cnt_inc;

    sccpu_stop_detect #(
        .HALT_INST (HALT_INST)
    ) u_stop (
        .pc_i       (bus.pc),
        .inst_i     (bus.inst),
        .bp_en_i    (bus.bp_en),
        .bp_addr_i  (bus.bp_addr),
        .bp_skip_i  (bp_skip_q),
        .hit_halt_o (hit_halt),
        .hit_bp_o   (hit_bp)
    );

    assign run_cnt_inc = run_cnt_q + CNT_W'(1);

    // Next state, halt reason, run flags and the Mealy cpu_en: a stop
    // condition suppresses the offending instruction in the same cycle.
    always_comb begin
        state_d   = state_q;
        rsn_d     = rsn_q;
        run_cnt_d = run_cnt_q;
        bp_skip_d = bp_skip_q;
        cpu_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // run beats step; halt_req is meaningless while stopped
                if (bus.run_req) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                    bp_skip_d = 1'b1;
                    rsn_d     = RSN_NONE;
                end else if (bus.step_req) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN: begin
                cpu_en = !bus.halt_req && !hit_halt && !hit_bp;
                if (cpu_en) begin
                    run_cnt_d = run_cnt_inc;
                    bp_skip_d = 1'b0;
                end

                if (bus.halt_req) begin
                    state_d = ST_HALT;
                    rsn_d   = RSN_USER;
                end else if (hit_halt) begin
                    state_d = ST_HALT;
                    rsn_d   = RSN_HINST;
                end else if (hit_bp) begin
                    state_d = ST_HALT;
                    rsn_d   = RSN_BP;
                end else if ((bus.max_cycles != '0) && (run_cnt_inc == bus.max_cycles)) begin
                    // budget exhausted: this last instruction still retires
                    state_d = ST_HALT;
                    rsn_d   = RSN_BUDGET;
                end

                if (state_d != ST_RUN) begin
                    bp_skip_d = 1'b0;
                end
            end

            ST_STEP: begin
                // breakpoints do not apply to a single step
                cpu_en  = !bus.halt_req && !hit_halt;
                state_d = ST_HALT;
                if (bus.halt_req) begin
                    rsn_d = RSN_USER;
                end else if (hit_halt) begin
                    rsn_d = RSN_HINST;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired counter and step completion pulse; clear wins over increment.
    always_comb begin
        retired_d   = retired_q;
        step_done_d = (state_q == ST_STEP) && cpu_en;
        if (bus.cnt_clr) begin
            retired_d = '0;
        end else if (cpu_en) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            rsn_q       <= RSN_NONE;
            step_done_q <= 1'b0;
            retired_q   <= '0;
            run_cnt_q   <= '0;
            bp_skip_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsn_q       <= rsn_d;
            step_done_q <= step_done_d;
            retired_q   <= retired_d;
            run_cnt_q   <= run_cnt_d;
            bp_skip_q   <= bp_skip_d;
        end
    end

    assign bus.cpu_en      = cpu_en;
    assign bus.state       = state_q;
    assign bus.halt_reason = rsn_q;
    assign bus.step_done   = step_done_q;
    assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_sccpu_run_ctrl.sv
// Bench for sccpu_run_ctrl: a cycle-level reference model of the run
// controller plus literal pins at the interesting points of each scenario.
module tb_sccpu_run_ctrl;

    localparam int          CW  = 32;
    localparam logic [31:0] HI  = 32'h0000_000C;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic Clock  = 1'b0;
    logic Resetn = 1'b1;
    always #5 Clock = ~Clock;

    sccpu_run_ctrl_if #(.CNT_W(CW)) bus();

    sccpu_run_ctrl #(
        .HALT_INST (HI),
        .CNT_W     (CW)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;
    logic [31:0] halt_pc = 32'hFFFF_FFF0;

    // literal expectations for the next sampling point
    bit          lit_vld = 1'b0;
    bit          lit_en;
    int          lit_st;
    int          lit_rsn;
    int          lit_cnt;
    bit          lit_sd;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 running, 2 single step, 3 stopped
    int          m_mode    = 0;
    int          m_rsn     = 0;
    logic [31:0] m_retired = '0;
    longint      m_left    = 0;
    bit          m_unlim   = 1'b1;
    bit          m_skip    = 1'b0;
    bit          m_sd      = 1'b0;
    bit          m_en, m_hh, m_hb;

    function automatic bit f_hit_halt();
        return bus.inst == HI;
    endfunction

    function automatic bit f_hit_bp();
        return bus.bp_en && ((bus.pc >> 2) == (bus.bp_addr >> 2)) && !m_skip;
    endfunction

    function automatic bit f_en();
        if (m_mode == 1) return !bus.halt_req && !f_hit_halt() && !f_hit_bp();
        if (m_mode == 2) return !bus.halt_req && !f_hit_halt();
        return 1'b0;
    endfunction

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_mode = 0; m_rsn = 0; m_retired = '0; m_left = 0;
            m_unlim = 1'b1; m_skip = 1'b0; m_sd = 1'b0;
        end else begin
            m_en = f_en();
            m_hh = f_hit_halt();
            m_hb = f_hit_bp();
            m_sd = (m_mode == 2) && m_en;
            m_retired = bus.cnt_clr ? 32'd0 : m_retired + {31'd0, m_en};
            case (m_mode)
                0, 3: begin
                    if (bus.run_req) begin
                        m_mode = 1; m_rsn = 0; m_skip = 1'b1;
                        m_unlim = (bus.max_cycles == 0);
                        m_left = longint'(bus.max_cycles);
                    end else if (bus.step_req) begin
                        m_mode = 2;
                    end
                end
                1: begin
                    if (m_en) begin
                        m_skip = 1'b0;
                        if (!m_unlim) m_left = m_left - 1;
                    end
                    if (bus.halt_req)              begin m_mode = 3; m_rsn = 1; end
                    else if (m_hh)                 begin m_mode = 3; m_rsn = 3; end
                    else if (m_hb)                 begin m_mode = 3; m_rsn = 2; end
                    else if (!m_unlim && m_left == 0) begin m_mode = 3; m_rsn = 4; end
                    if (m_mode != 1) m_skip = 1'b0;
                end
                default: begin
                    m_mode = 3;
                    if (bus.halt_req) m_rsn = 1;
                    else if (m_hh)    m_rsn = 3;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_on) begin
            chk("cpu_en",      64'(bus.cpu_en),      64'(f_en()));
            chk("state",       64'(bus.state),       64'(m_mode));
            chk("halt_reason", 64'(bus.halt_reason), 64'(m_rsn));
            chk("step_done",   64'(bus.step_done),   64'(m_sd));
            chk("retired_cnt", 64'(bus.retired_cnt), 64'(m_retired));
            if (lit_vld) begin
                chk("pin_cpu_en",  64'(bus.cpu_en),      64'(lit_en));
                chk("pin_state",   64'(bus.state),       64'(lit_st));
                chk("pin_reason",  64'(bus.halt_reason), 64'(lit_rsn));
                chk("pin_retired", 64'(bus.retired_cnt), 64'(lit_cnt));
                chk("pin_stepdone",64'(bus.step_done),   64'(lit_sd));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_inst();
        bus.inst = (bus.pc == halt_pc) ? HI : NOP;
    endtask

    task automatic setpc(input logic [31:0] v);
        bus.pc = v;
        set_inst();
    endtask

    task automatic pin(input bit en, input int st, input int rsn, input int cnt, input bit sd);
        lit_en = en; lit_st = st; lit_rsn = rsn; lit_cnt = cnt; lit_sd = sd;
        lit_vld = 1'b1;
    endtask

    // one cycle: sample, clock, then advance the fake fetch if it retired
    task automatic cyc();
        bit en_s;
        @(negedge Clock);
        en_s = bus.cpu_en;
        @(posedge Clock);
        #1;
        lit_vld      = 1'b0;
        bus.run_req  = 1'b0;
        bus.step_req = 1'b0;
        bus.halt_req = 1'b0;
        bus.cnt_clr  = 1'b0;
        if (en_s) bus.pc = bus.pc + 32'd4;
        set_inst();
    endtask

    initial begin
        bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0; bus.cnt_clr = 0;
        bus.bp_en = 0; bus.bp_addr = '0; bus.max_cycles = '0;
        setpc(32'h0);
        #2 Resetn = 1'b0;
        chk_on = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Resetn = 1'b1;

        // reset state
        pin(0, 0, 0, 0, 0); cyc();

        // run and step together: run wins
        bus.run_req = 1; bus.step_req = 1; cyc();
        pin(1, 1, 0, 0, 0); cyc();
        bus.halt_req = 1; pin(0, 1, 0, 1, 0); cyc();
        // halt_req while stopped has no effect
        bus.halt_req = 1; pin(0, 3, 1, 1, 0); cyc();
        bus.cnt_clr = 1; setpc(32'h0); cyc();

        // free run, 10 instructions
        bus.run_req = 1; cyc();
        repeat (10) cyc();
        pin(1, 1, 0, 10, 0); cyc();
        bus.halt_req = 1; pin(0, 1, 0, 11, 0); cyc();
        pin(0, 3, 1, 11, 0); bus.cnt_clr = 1; setpc(32'h0); cyc();

        // breakpoint at 0x10 (low bits of bp_addr ignored)
        bus.bp_en = 1; bus.bp_addr = 32'h0000_0013;
        bus.run_req = 1; cyc();
        repeat (4) cyc();
        pin(0, 1, 0, 4, 0); cyc();
        pin(0, 3, 2, 4, 0); bus.run_req = 1; cyc();
        pin(1, 1, 0, 4, 0); cyc();
        pin(1, 1, 0, 5, 0); cyc();
        bus.halt_req = 1; pin(0, 1, 0, 6, 0); cyc();

        // single step at 0x20, then at the breakpoint address
        setpc(32'h20); bus.step_req = 1; pin(0, 3, 1, 6, 0); cyc();
        pin(1, 2, 1, 6, 0); cyc();
        pin(0, 3, 1, 7, 1); cyc();
        pin(0, 3, 1, 7, 0); cyc();
        setpc(32'h10); bus.step_req = 1; cyc();
        pin(1, 2, 1, 7, 0); cyc();
        pin(0, 3, 1, 8, 1); cyc();

        // halt instruction at 0x30
        halt_pc = 32'h30; setpc(32'h28); bus.run_req = 1; cyc();
        cyc(); cyc();
        pin(0, 1, 0, 10, 0); cyc();
        pin(0, 3, 3, 10, 0); bus.run_req = 1; cyc();
        pin(0, 1, 0, 10, 0); cyc();
        pin(0, 3, 3, 10, 0); bus.step_req = 1; cyc();
        pin(0, 2, 3, 10, 0); cyc();
        pin(0, 3, 3, 10, 0); cyc();

        // cycle budget of 5
        halt_pc = 32'hFFFF_FFF0; bus.bp_en = 0; bus.max_cycles = 5;
        setpc(32'h100); bus.run_req = 1; cyc();
        repeat (4) cyc();
        pin(1, 1, 0, 14, 0); cyc();
        pin(0, 3, 4, 15, 0); bus.max_cycles = 0; bus.run_req = 1; cyc();
        cyc(); cyc();
        bus.halt_req = 1; pin(0, 1, 0, 17, 0); cyc();
        pin(0, 3, 1, 17, 0); cyc();

        // counter clear on an enabled cycle
        bus.run_req = 1; cyc();
        cyc();
        bus.cnt_clr = 1; pin(1, 1, 0, 18, 0); cyc();
        pin(1, 1, 0, 0, 0); cyc();
        pin(1, 1, 0, 1, 0); cyc();

        // async reset in the middle of a run
        #2 Resetn = 1'b0;
        pin(0, 0, 0, 0, 0); cyc();
        Resetn = 1'b1;
        pin(0, 0, 0, 0, 0); cyc();
        repeat (2) cyc();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
